// File: rtl/tetris_pkg.sv
// Shared constants and types for the score keeper, display path and gravity timer.
package tetris_pkg;

  localparam int unsigned SCORE_W = 13;
  localparam int unsigned LINES_W = 10;
  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned LMOD_W  = 4;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned BASE_W  = 7;
  localparam int unsigned CLR_W   = 3;

  localparam int unsigned DEF_SCORE_MAX       = 8191;
  localparam int unsigned DEF_LINES_MAX       = 999;
  localparam int unsigned DEF_LEVEL_MAX       = 15;
  localparam int unsigned DEF_LINES_PER_LEVEL = 10;

  localparam logic [BASE_W-1:0] PTS_1 = 7'd4;
  localparam logic [BASE_W-1:0] PTS_2 = 7'd10;
  localparam logic [BASE_W-1:0] PTS_3 = 7'd30;
  localparam logic [BASE_W-1:0] PTS_4 = 7'd120;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_LVL  = 2'd2
  } state_e;

  // Zero marks an illegal line count; such events are consumed without effect.
  function automatic logic [BASE_W-1:0] base_points(input logic [CLR_W-1:0] n);
    case (n)
      3'd1:    return PTS_1;
      3'd2:    return PTS_2;
      3'd3:    return PTS_3;
      3'd4:    return PTS_4;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/sat_add.sv
// Unsigned adder that clamps its result to a ceiling.
module sat_add #(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  localparam int unsigned WS = W + 1;
  localparam logic [W:0]  MAX_V = WS'(MAX);

  logic [W:0] sum_c;

  always_comb begin
    sum_c = {1'b0, a_i} + {1'b0, b_i};
    y_o   = (sum_c > MAX_V) ? MAX_V[W-1:0] : sum_c[W-1:0];
  end

endmodule

// File: rtl/tetris_score.sv
// Score/lines/level keeper: accepts line-clear events and multiplies base points
// by (level+1) through repeated addition.
module tetris_score
  import tetris_pkg::*;
#(
  parameter int unsigned SCORE_MAX       = DEF_SCORE_MAX,
  parameter int unsigned LINES_MAX       = DEF_LINES_MAX,
  parameter int unsigned LEVEL_MAX       = DEF_LEVEL_MAX,
  parameter int unsigned LINES_PER_LEVEL = DEF_LINES_PER_LEVEL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_reset,
  input  logic               clr_valid,
  output logic               clr_ready,
  input  logic [CLR_W-1:0]   clr_lines,
  input  logic               drop_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [LINES_W-1:0] lines,
  output logic [LEVEL_W-1:0] level,
  output logic               busy
);

  state_e              state_q, state_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [LINES_W-1:0]  lines_q, lines_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [LMOD_W-1:0]   lmod_q, lmod_d;

  logic [SCORE_W-1:0]  score_inc_c, score_sum_c;
  logic [LINES_W-1:0]  lines_sum_c;
  logic [BASE_W-1:0]   clr_base_c;
  logic                hs_c;

  assign clr_ready  = (state_q == ST_IDLE) && !game_reset;
  assign busy       = (state_q != ST_IDLE);
  assign hs_c       = clr_valid && clr_ready;
  assign clr_base_c = base_points(clr_lines);

  // A drop landing on an ADD step is folded into that same addition.
  always_comb begin
    score_inc_c = SCORE_W'(drop_pulse);
    if (state_q == ST_ADD) score_inc_c = score_inc_c + SCORE_W'(base_q);
  end

  sat_add #(.W(SCORE_W), .MAX(SCORE_MAX)) u_score_add (
    .a_i (score_q),
    .b_i (score_inc_c),
    .y_o (score_sum_c)
  );

  sat_add #(.W(LINES_W), .MAX(LINES_MAX)) u_lines_add (
    .a_i (lines_q),
    .b_i (LINES_W'(clr_lines)),
    .y_o (lines_sum_c)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    score_d = score_sum_c;
    lines_d = lines_q;
    level_d = level_q;
    lmod_d  = lmod_q;
    if (game_reset) begin
      state_d = ST_IDLE;
      base_d  = '0;
      cnt_d   = '0;
      score_d = '0;
      lines_d = '0;
      level_d = '0;
      lmod_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hs_c && (clr_base_c != '0)) begin
            base_d  = clr_base_c;
            cnt_d   = CNT_W'(level_q) + CNT_W'(1);
            lines_d = lines_sum_c;
            lmod_d  = lmod_q + LMOD_W'(clr_lines);
            state_d = ST_ADD;
          end
        end
        ST_ADD: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_LVL;
        end
        ST_LVL: begin
          if (lmod_q >= LMOD_W'(LINES_PER_LEVEL)) begin
            lmod_d = lmod_q - LMOD_W'(LINES_PER_LEVEL);
            if (level_q != LEVEL_W'(LEVEL_MAX)) level_d = level_q + LEVEL_W'(1);
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      score_q <= '0;
      lines_q <= '0;
      level_q <= '0;
      lmod_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      lines_q <= lines_d;
      level_q <= level_d;
      lmod_q  <= lmod_d;
    end
  end

  assign score = score_q;
  assign lines = lines_q;
  assign level = level_q;

endmodule

// File: doc/tetris_score.md
Name: tetris_score

Overview:
Score, line and level keeper for the game core. It accepts line-clear events from the playfield logic through a valid/ready handshake and soft-drop pulses. It accumulates the score with a multi-cycle multiply-by-repeated-addition FSM. Its 13-bit `score` output drives the seven-segment display driver's `num` input directly, and `level` feeds the gravity timer.

Parameters:
SCORE_MAX, 8191, saturation ceiling for score (full 13-bit range)
LINES_MAX, 999, saturation ceiling for the lines counter
LEVEL_MAX, 15, saturation ceiling for level
LINES_PER_LEVEL, 10, cleared lines needed per level step

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
game_reset  in  1  synchronous clear for a new game, active-high
clr_valid  in  1  line-clear event valid
clr_ready  out  1  block can accept a clear event
clr_lines  in  3  number of lines cleared in the event; legal values 1..4
drop_pulse  in  1  one-cycle soft-drop strobe, worth +1 point
score  out  13  current score, binary
lines  out  10  total lines cleared
level  out  4  current level
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_n low, asynchronous) forces the following:
  - score=0, lines=0, level=0, lines_mod=0
  - state=IDLE
  - busy=0
  - clr_ready=1 once rst_n has been released
- game_reset=1 at a clock edge:
  - Loads the same values as rst_n.
  - Overrides every other input that cycle. clr_ready is forced 0 combinationally while game_reset=1, so no handshake completes.
  - drop_pulse is ignored that cycle.
- clr_ready = (state==IDLE) && !game_reset. A handshake completes on a clock edge where clr_valid && clr_ready.
- Base points by clr_lines:
  - 1 → 4
  - 2 → 10
  - 3 → 30
  - 4 → 120
  - 0 or 5..7 → event consumed, no score/lines/level change, state stays IDLE.
- State IDLE, on a legal handshake:
  - latch base
  - latch cnt = level+1 (level before this clear)
  - lines = min(lines+clr_lines, LINES_MAX)
  - lines_mod += clr_lines
  - go to ADD
- State ADD:
  - Each cycle, score = min(score + base + drop_pulse, SCORE_MAX) and cnt decrements.
  - Go to LVL on the edge where cnt==1.
  - ADD lasts exactly level+1 cycles.
- State LVL (one cycle):
  - If lines_mod >= LINES_PER_LEVEL: lines_mod -= LINES_PER_LEVEL and level = min(level+1, LEVEL_MAX). At most one level step per event, since clr_lines ≤ 4.
  - Go to IDLE.
  - drop_pulse still applies in this state.
- Latency, with handshake at edge t0:
  - ADD occupies edges t1..tk (k = old level+1)
  - level updates at edge tk+1
  - clr_ready=1 again after edge tk+1
  - Total busy time is k+1 cycles.
- drop_pulse is applied in every state, including IDLE: score = min(score+1, SCORE_MAX). A drop coinciding with an ADD step is summed into that same step; it is never lost or double-counted.
- Arithmetic:
  - Do the sum in 14 bits, compare against SCORE_MAX, and clamp.
  - lines: 11-bit sum, clamp to LINES_MAX.
  - lines_mod: 4-bit, range 0..13.
- Once level==LEVEL_MAX, level stays fixed; lines_mod still wraps so no overflow occurs.
- Once score==SCORE_MAX, it stays there; the FSM still runs its full ADD/LVL cycle count.
- All outputs are registered except clr_ready and busy, which decode directly from the state register.

Decomposition:
- Shared package (tetris_pkg) holds:
  - state encoding IDLE/ADD/LVL
  - the base-points constants for 1/2/3/4 lines
  - SCORE_MAX / LINES_MAX / LEVEL_MAX defaults, so the display path and gravity timer agree on widths
- One sub-module is natural: sat_add, a parameterised width adder that clamps to a ceiling. It is instantiated for score and lines.

Test Plan:
1. Reset: assert rst_n low mid-clock → score=0, lines=0, level=0, busy=0 immediately; clr_ready=1 after release.
2. Level 0, clr_lines=4 handshake → busy for 2 cycles, score=120, lines=4, level=0; clr_ready high on cycle 3.
3. Ten clr_lines=1 events from reset → score=40, level=1 after the 10th event's LVL cycle. An 11th single clear → ADD lasts 2 cycles, score=48, lines=11.
4. Saturation: drive score to 8100 at level 0, then clr_lines=4 → score=8191. Further drop_pulse → stays at 8191.
5. drop_pulse asserted on the ADD cycle of a clr_lines=2 event at level 0 → score +11 total. drop_pulse in IDLE → +1.
6. game_reset during ADD with clr_valid held high → all counters 0 next edge, no handshake that cycle. The next cycle's clr_lines=3 is accepted → score=30.
7. clr_lines=0 and clr_lines=5 handshakes → accepted, no state change, busy stays 0.
